// File: rtl/dma_chn_sched.sv
// Channel request scheduler for the 16-channel DMA. It latches requests, arbitrates
// through the external priority decoder, then launches and tracks one transfer at a time.
module dma_chn_sched #(
  parameter int          CHN_MUX_W = 4,
  parameter int          TMO_W     = 16,
  parameter int unsigned TMO_MAX   = 16'hFFFF
) (
  input  logic                 hclk,
  input  logic                 hrst,
  input  logic [15:0]          chn_req,
  input  logic [15:0]          chn_en,
  output logic [15:0]          chntrg_all,
  input  logic [15:0]          actv_chn_cod,
  output logic [15:0]          chn_ack,
  output logic                 xfer_start,
  output logic [CHN_MUX_W-1:0] xfer_chn,
  input  logic                 xfer_done,
  input  logic                 xfer_err,
  output logic                 chn_busy,
  output logic [15:0]          chn_done_int,
  output logic [15:0]          chn_err_int
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ARB  = 2'd1;
  localparam logic [1:0] S_BUSY = 2'd2;

  localparam bit               TMO_EN   = (TMO_MAX != 0);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_MAX - 1);

  logic [1:0]           state_q, state_d;
  logic [15:0]          pend_q, pend_d;
  logic [CHN_MUX_W-1:0] xfer_chn_q, xfer_chn_d;
  logic [TMO_W-1:0]     tmo_cnt_q, tmo_cnt_d;
  logic [15:0]          ack_q, ack_d;
  logic                 start_q, start_d;
  logic [15:0]          done_q, done_d;
  logic [15:0]          err_q, err_d;

  logic [15:0]          grant_vec;
  logic [CHN_MUX_W-1:0] cod_idx;
  logic                 cod_ok;
  logic [15:0]          chn_oh;
  logic                 tmo_hit;

  assign chntrg_all   = pend_q & chn_en;
  assign chn_ack      = ack_q;
  assign xfer_start   = start_q;
  assign xfer_chn     = xfer_chn_q;
  assign chn_busy     = (state_q != S_IDLE);
  assign chn_done_int = done_q;
  assign chn_err_int  = err_q;

  assign chn_oh  = 16'd1 << xfer_chn_q;
  assign tmo_hit = TMO_EN && (tmo_cnt_q == TMO_LAST);

  // A decoder code is trusted only when exactly one bit is set.
  always_comb begin
    cod_idx = '0;
    for (int i = 0; i < 16; i++) begin
      if (actv_chn_cod[i]) cod_idx = CHN_MUX_W'(i);
    end
    cod_ok = (actv_chn_cod != 16'd0) &&
             ((actv_chn_cod & (actv_chn_cod - 16'd1)) == 16'd0);
  end

  always_comb begin
    state_d    = state_q;
    xfer_chn_d = xfer_chn_q;
    tmo_cnt_d  = tmo_cnt_q;
    ack_d      = '0;
    start_d    = 1'b0;
    done_d     = '0;
    err_d      = '0;
    grant_vec  = '0;
    case (state_q)
      S_IDLE: begin
        if (chntrg_all != 16'd0) state_d = S_ARB;
      end
      S_ARB: begin
        if (cod_ok) begin
          grant_vec  = actv_chn_cod;
          xfer_chn_d = cod_idx;
          ack_d      = actv_chn_cod;
          start_d    = 1'b1;
          tmo_cnt_d  = '0;
          state_d    = S_BUSY;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        tmo_cnt_d = tmo_cnt_q + 1'b1;
        // Error (bus or watchdog) takes precedence over a simultaneous done.
        if (xfer_err || tmo_hit) begin
          err_d   = chn_oh;
          state_d = S_IDLE;
        end else if (xfer_done) begin
          done_d  = chn_oh;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // Disable and grant both clear, and win over a request still held high.
    pend_d = (pend_q | chn_req) & ~grant_vec & chn_en;
  end

  always_ff @(posedge hclk or posedge hrst) begin
    if (hrst) begin
      state_q    <= S_IDLE;
      pend_q     <= '0;
      xfer_chn_q <= '0;
      tmo_cnt_q  <= '0;
      ack_q      <= '0;
      start_q    <= 1'b0;
      done_q     <= '0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      xfer_chn_q <= xfer_chn_d;
      tmo_cnt_q  <= tmo_cnt_d;
      ack_q      <= ack_d;
      start_q    <= start_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_dma_chn_sched.sv
// Bench for dma_chn_sched: a per-cycle vector table plus hand sequences for priority,
// decoder fault, watchdog and mid-transfer reset. Two instances differ only in TMO_MAX.
module tb_dma_chn_sched;

  logic        hclk = 1'b0;
  logic        hrst = 1'b1;
  logic [15:0] chn_req = '0;
  logic [15:0] chn_en = '0;
  logic        xfer_done = 1'b0;
  logic        xfer_err = 1'b0;
  logic        dec_fault = 1'b0;
  logic [15:0] fault_cod = '0;

  logic [15:0] trg8, cod8, ack8, done8, err8;
  logic        start8, busy8;
  logic [3:0]  chn8;
  logic [15:0] trg0, cod0, ack0, done0, err0;
  logic        start0, busy0;
  logic [3:0]  chn0;

  // Priority decoder model: lowest set bit wins, or a forced faulty code.
  assign cod8 = dec_fault ? fault_cod : (trg8 & (~trg8 + 16'd1));
  assign cod0 = dec_fault ? fault_cod : (trg0 & (~trg0 + 16'd1));

  dma_chn_sched #(.CHN_MUX_W(4), .TMO_W(16), .TMO_MAX(8)) u_dut8 (
    .hclk(hclk), .hrst(hrst), .chn_req(chn_req), .chn_en(chn_en),
    .chntrg_all(trg8), .actv_chn_cod(cod8), .chn_ack(ack8),
    .xfer_start(start8), .xfer_chn(chn8), .xfer_done(xfer_done),
    .xfer_err(xfer_err), .chn_busy(busy8), .chn_done_int(done8),
    .chn_err_int(err8)
  );

  dma_chn_sched #(.CHN_MUX_W(4), .TMO_W(16), .TMO_MAX(0)) u_dut0 (
    .hclk(hclk), .hrst(hrst), .chn_req(chn_req), .chn_en(chn_en),
    .chntrg_all(trg0), .actv_chn_cod(cod0), .chn_ack(ack0),
    .xfer_start(start0), .xfer_chn(chn0), .xfer_done(xfer_done),
    .xfer_err(xfer_err), .chn_busy(busy0), .chn_done_int(done0),
    .chn_err_int(err0)
  );

  always #5 hclk = ~hclk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    logic [15:0] req, en;
    logic        dn, er;
    logic [15:0] trg, ack;
    logic        st;
    logic [3:0]  chn;
    logic        busy;
    logic [15:0] dint, eint;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge hclk);
    #1;
    cyc++;
  endtask

  function automatic void add(input logic [15:0] req, input logic [15:0] en,
                              input logic dn, input logic er,
                              input logic [15:0] trg, input logic [15:0] ack,
                              input logic st, input logic [3:0] chn, input logic busy,
                              input logic [15:0] dint, input logic [15:0] eint);
    vec_t v;
    v.req = req; v.en = en; v.dn = dn; v.er = er;
    v.trg = trg; v.ack = ack; v.st = st; v.chn = chn; v.busy = busy;
    v.dint = dint; v.eint = eint;
    tbl.push_back(v);
  endfunction

  task automatic chk_idle_all(input string tag);
    chk({tag, " trg"}, trg8, 16'h0);
    chk({tag, " ack"}, ack8, 16'h0);
    chk({tag, " start"}, start8, 1'b0);
    chk({tag, " chn"}, chn8, 4'd0);
    chk({tag, " busy"}, busy8, 1'b0);
    chk({tag, " done"}, done8, 16'h0);
    chk({tag, " err"}, err8, 16'h0);
  endtask

  initial begin
    int s_cyc, d_cyc;
    bit found, dropped;
    logic [15:0] gack;
    int exp_ch [3];
    exp_ch[0] = 2; exp_ch[1] = 8; exp_ch[2] = 15;

    // single channel 5 with done after four busy cycles, plus done/err in IDLE
    add(16'h0020, 16'h0020, 0, 0, 16'h0020, 16'h0, 0, 4'd0, 0, 16'h0, 16'h0);
    add(16'h0000, 16'h0020, 0, 0, 16'h0020, 16'h0, 0, 4'd0, 1, 16'h0, 16'h0);
    add(16'h0000, 16'h0020, 0, 0, 16'h0000, 16'h0020, 1, 4'd5, 1, 16'h0, 16'h0);
    add(16'h0000, 16'h0020, 0, 0, 16'h0000, 16'h0, 0, 4'd5, 1, 16'h0, 16'h0);
    add(16'h0000, 16'h0020, 0, 0, 16'h0000, 16'h0, 0, 4'd5, 1, 16'h0, 16'h0);
    add(16'h0000, 16'h0020, 0, 0, 16'h0000, 16'h0, 0, 4'd5, 1, 16'h0, 16'h0);
    add(16'h0000, 16'h0020, 1, 0, 16'h0000, 16'h0, 0, 4'd5, 0, 16'h0020, 16'h0);
    add(16'h0000, 16'h0020, 0, 0, 16'h0000, 16'h0, 0, 4'd5, 0, 16'h0, 16'h0);
    add(16'h0000, 16'h0020, 1, 0, 16'h0000, 16'h0, 0, 4'd5, 0, 16'h0, 16'h0);
    add(16'h0000, 16'h0020, 0, 1, 16'h0000, 16'h0, 0, 4'd5, 0, 16'h0, 16'h0);
    // channel 3: done and err together, error wins
    add(16'h0008, 16'h0008, 0, 0, 16'h0008, 16'h0, 0, 4'd5, 0, 16'h0, 16'h0);
    add(16'h0000, 16'h0008, 0, 0, 16'h0008, 16'h0, 0, 4'd5, 1, 16'h0, 16'h0);
    add(16'h0000, 16'h0008, 0, 0, 16'h0000, 16'h0008, 1, 4'd3, 1, 16'h0, 16'h0);
    add(16'h0000, 16'h0008, 1, 1, 16'h0000, 16'h0, 0, 4'd3, 0, 16'h0, 16'h0008);
    add(16'h0000, 16'h0008, 0, 0, 16'h0000, 16'h0, 0, 4'd3, 0, 16'h0, 16'h0);
    // channel 10: done in the same cycle as xfer_start
    add(16'h0400, 16'h0400, 0, 0, 16'h0400, 16'h0, 0, 4'd3, 0, 16'h0, 16'h0);
    add(16'h0000, 16'h0400, 0, 0, 16'h0400, 16'h0, 0, 4'd3, 1, 16'h0, 16'h0);
    add(16'h0000, 16'h0400, 0, 0, 16'h0000, 16'h0400, 1, 4'd10, 1, 16'h0, 16'h0);
    add(16'h0000, 16'h0400, 1, 0, 16'h0000, 16'h0, 0, 4'd10, 0, 16'h0400, 16'h0);
    add(16'h0000, 16'h0400, 0, 0, 16'h0000, 16'h0, 0, 4'd10, 0, 16'h0, 16'h0);
    // channel 7: enable dropped during BUSY, transfer still ends with err
    add(16'h0080, 16'h0080, 0, 0, 16'h0080, 16'h0, 0, 4'd10, 0, 16'h0, 16'h0);
    add(16'h0000, 16'h0080, 0, 0, 16'h0080, 16'h0, 0, 4'd10, 1, 16'h0, 16'h0);
    add(16'h0000, 16'h0080, 0, 0, 16'h0000, 16'h0080, 1, 4'd7, 1, 16'h0, 16'h0);
    add(16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0, 0, 4'd7, 1, 16'h0, 16'h0);
    add(16'h0000, 16'h0000, 0, 1, 16'h0000, 16'h0, 0, 4'd7, 0, 16'h0, 16'h0080);
    add(16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0, 0, 4'd7, 0, 16'h0, 16'h0);
    // channel 1: enable dropped in the ARB cycle, no grant
    add(16'h0002, 16'h0002, 0, 0, 16'h0002, 16'h0, 0, 4'd7, 0, 16'h0, 16'h0);
    add(16'h0000, 16'h0002, 0, 0, 16'h0002, 16'h0, 0, 4'd7, 1, 16'h0, 16'h0);
    add(16'h0000, 16'h0000, 0, 0, 16'h0000, 16'h0, 0, 4'd7, 0, 16'h0, 16'h0);
    add(16'h0000, 16'h0002, 0, 0, 16'h0000, 16'h0, 0, 4'd7, 0, 16'h0, 16'h0);
    add(16'h0000, 16'h0002, 0, 0, 16'h0000, 16'h0, 0, 4'd7, 0, 16'h0, 16'h0);

    // reset held with every request and enable high
    chn_req = 16'hFFFF;
    chn_en  = 16'hFFFF;
    step(); step(); step();
    chk_idle_all("reset");
    chk("reset trg0", trg0, 16'h0);
    hrst = 1'b0;
    step();
    chk("post-reset trg", trg8, 16'hFFFF);
    chk("post-reset busy", busy8, 1'b0);
    chn_req = 16'h0;
    chn_en  = 16'h0;
    hrst = 1'b1;
    step();
    hrst = 1'b0;
    step();
    chk_idle_all("clean");

    foreach (tbl[i]) begin
      chn_req   = tbl[i].req;
      chn_en    = tbl[i].en;
      xfer_done = tbl[i].dn;
      xfer_err  = tbl[i].er;
      step();
      chk($sformatf("vec%0d trg", i), trg8, tbl[i].trg);
      chk($sformatf("vec%0d ack", i), ack8, tbl[i].ack);
      chk($sformatf("vec%0d start", i), start8, tbl[i].st);
      chk($sformatf("vec%0d chn", i), chn8, tbl[i].chn);
      chk($sformatf("vec%0d busy", i), busy8, tbl[i].busy);
      chk($sformatf("vec%0d done", i), done8, tbl[i].dint);
      chk($sformatf("vec%0d err", i), err8, tbl[i].eint);
    end
    xfer_done = 1'b0;
    xfer_err  = 1'b0;

    // decoder returns a two-hot code: no grant, request survives and wins later
    chn_en  = 16'h0010;
    chn_req = 16'h0010;
    step();
    chn_req = 16'h0;
    step();
    chk("fault arb busy", busy8, 1'b1);
    dec_fault = 1'b1;
    fault_cod = 16'h0030;
    step();
    dec_fault = 1'b0;
    chk("fault busy", busy8, 1'b0);
    chk("fault start", start8, 1'b0);
    chk("fault ack", ack8, 16'h0);
    chk("fault trg kept", trg8, 16'h0010);
    step();
    step();
    chk("fault retry start", start8, 1'b1);
    chk("fault retry chn", chn8, 4'd4);
    xfer_done = 1'b1;
    step();
    xfer_done = 1'b0;
    chk("fault retry done", done8, 16'h0010);
    chn_en = 16'h0;
    step();

    // priority: 2, 8, 15 with held requests dropped on ack
    chn_en  = 16'hFFFF;
    chn_req = 16'h8104;
    d_cyc = 0;
    for (int g = 0; g < 3; g++) begin
      found = 1'b0;
      for (int w = 0; w < 20 && !found; w++) begin
        step();
        if (start8) found = 1'b1;
      end
      if (!found) begin
        chk($sformatf("prio%0d start seen", g), 0, 1);
      end else begin
        chk($sformatf("prio%0d chn", g), chn8, exp_ch[g]);
        chk($sformatf("prio%0d ack", g), ack8, 32'd1 << exp_ch[g]);
        if (g > 0) chk($sformatf("prio%0d gap", g), cyc - d_cyc, 2);
      end
      gack = ack8;
      chn_req = chn_req & ~gack;
      step();
      xfer_done = 1'b1;
      step();
      xfer_done = 1'b0;
      d_cyc = cyc;
      chk($sformatf("prio%0d done", g), done8, gack);
    end
    step();
    chk("prio idle", busy8, 1'b0);
    chn_en = 16'h0;
    step();

    // watchdog: TMO_MAX=8 errors 8 cycles after start, TMO_MAX=0 stays busy
    chn_en  = 16'h0040;
    chn_req = 16'h0040;
    step();
    chn_req = 16'h0;
    found = 1'b0;
    s_cyc = 0;
    for (int w = 0; w < 10 && !found; w++) begin
      step();
      if (start8) begin found = 1'b1; s_cyc = cyc; end
    end
    chk("tmo start seen", found, 1'b1);
    chk("tmo chn", chn8, 4'd6);
    found = 1'b0;
    for (int w = 0; w < 20 && !found; w++) begin
      step();
      if (err8 != 16'h0) found = 1'b1;
    end
    chk("tmo err seen", found, 1'b1);
    chk("tmo latency", cyc - s_cyc, 8);
    chk("tmo err chn", err8, 16'h0040);
    chk("tmo done", done8, 16'h0);
    step();
    chk("tmo idle", busy8, 1'b0);
    dropped = 1'b0;
    for (int w = 0; w < 1000; w++) begin
      step();
      if (!busy0 || err0 != 16'h0) dropped = 1'b1;
    end
    chk("wdog off still busy", dropped, 1'b0);
    chk("wdog off chn", chn0, 4'd6);

    // asynchronous reset mid-BUSY
    #2;
    hrst = 1'b1;
    #1;
    chk("mid-reset busy", busy0, 1'b0);
    chk("mid-reset chn", chn0, 4'd0);
    xfer_done = 1'b1;
    step();
    hrst = 1'b0;
    step();
    xfer_done = 1'b0;
    chk("mid-reset done", done0, 16'h0);
    chk("mid-reset err", err0, 16'h0);
    chk("mid-reset still idle", busy0, 1'b0);
    chk("mid-reset chn held", chn0, 4'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
